// File: rtl/prt_dprx_scrm.sv
// DisplayPort RX per-lane descrambler: one x^16+x^5+x^4+x^3+1 LFSR per lane,
// reseeded on SR symbols, P_SPL symbols per lane chained per clock.
module prt_dprx_scrm #(
  parameter int unsigned P_LANES = 4,
  parameter int unsigned P_SPL   = 2
) (
  input  logic                           CLK_IN,
  input  logic                           RST_IN,
  input  logic                           CTL_LNK_EN_IN,
  input  logic                           CTL_LANES_IN,
  input  logic                           CTL_SCRM_EN_IN,
  input  logic [P_LANES*P_SPL*9-1:0]     LNK_DAT_IN,
  input  logic                           LNK_VLD_IN,
  output logic [P_LANES*P_SPL*9-1:0]     LNK_DAT_OUT,
  output logic                           LNK_VLD_OUT,
  output logic [P_LANES-1:0]             STA_SYNC_OUT
);

  localparam int unsigned LP_SYM_W  = 9;
  localparam int unsigned LP_LANE_W = P_SPL * LP_SYM_W;
  localparam int unsigned LP_DAT_W  = P_LANES * LP_LANE_W;
  localparam logic [15:0] LP_SEED   = 16'hFFFF;
  localparam logic [8:0]  LP_SR     = 9'h11C;

  logic [P_LANES-1:0][15:0] r_lfsr;
  logic [P_LANES-1:0]       r_sync;
  logic [LP_DAT_W-1:0]      r_dat;
  logic                     r_vld;
  logic                     r_lanes;

  logic [P_LANES-1:0][15:0] w_lfsr_nxt;
  logic [P_LANES-1:0]       w_sync_nxt;
  logic [LP_DAT_W-1:0]      w_dat_nxt;
  logic                     w_vld_nxt;
  logic                     w_lanes_chg;
  logic [15:0]              w_lf;
  logic [8:0]               w_sym;
  logic [23:0]              w_step;

  // Eight LFSR steps; returns {key byte (first bit in bit 0), next state}.
  function automatic logic [23:0] f_step8(input logic [15:0] i_lfsr);
    logic [15:0] v_lf;
    logic [7:0]  v_key;
    v_lf  = i_lfsr;
    v_key = 8'h00;
    for (int b = 0; b < 8; b++) begin
      v_key[b] = v_lf[15];
      v_lf     = {v_lf[14:0], 1'b0} ^ (v_lf[15] ? 16'h0039 : 16'h0000);
    end
    return {v_key, v_lf};
  endfunction

  always_comb begin
    w_lfsr_nxt  = r_lfsr;
    w_sync_nxt  = r_sync;
    w_dat_nxt   = r_dat;
    w_vld_nxt   = 1'b0;
    w_lf        = LP_SEED;
    w_sym       = 9'h000;
    w_step      = 24'h000000;
    w_lanes_chg = (CTL_LANES_IN != r_lanes);
    if (!CTL_LNK_EN_IN) begin
      w_lfsr_nxt = {P_LANES{LP_SEED}};
      w_sync_nxt = '0;
      w_dat_nxt  = '0;
    end else begin
      w_vld_nxt = LNK_VLD_IN;
      for (int l = 0; l < int'(P_LANES); l++) begin
        if (l >= 2 && !CTL_LANES_IN) begin
          w_lfsr_nxt[l] = LP_SEED;
          w_sync_nxt[l] = 1'b0;
          if (LNK_VLD_IN) w_dat_nxt[l*LP_LANE_W +: LP_LANE_W] = '0;
        end else if (LNK_VLD_IN) begin
          w_lf = r_lfsr[l];
          // Sublanes chain: each symbol sees the state left by the previous one.
          for (int s = 0; s < int'(P_SPL); s++) begin
            w_sym  = LNK_DAT_IN[(l*P_SPL + s)*LP_SYM_W +: LP_SYM_W];
            w_step = f_step8(w_lf);
            if (w_sym == LP_SR) begin
              w_lf          = LP_SEED;
              w_sync_nxt[l] = 1'b1;
            end else begin
              w_lf = w_step[15:0];
              if (!w_sym[8] && CTL_SCRM_EN_IN) w_sym[7:0] = w_sym[7:0] ^ w_step[23:16];
            end
            w_dat_nxt[(l*P_SPL + s)*LP_SYM_W +: LP_SYM_W] = w_sym;
          end
          w_lfsr_nxt[l] = w_lf;
        end
      end
      // A lane-count change overrides any SR/data update in the same cycle.
      if (w_lanes_chg) begin
        w_lfsr_nxt = {P_LANES{LP_SEED}};
        w_sync_nxt = '0;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_lfsr  <= {P_LANES{LP_SEED}};
      r_sync  <= '0;
      r_dat   <= '0;
      r_vld   <= 1'b0;
      r_lanes <= CTL_LANES_IN;
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_sync  <= w_sync_nxt;
      r_dat   <= w_dat_nxt;
      r_vld   <= w_vld_nxt;
      r_lanes <= CTL_LANES_IN;
    end
  end

  assign LNK_DAT_OUT  = r_dat;
  assign LNK_VLD_OUT  = r_vld;
  assign STA_SYNC_OUT = r_sync;

endmodule

// File: tb/tb_prt_dprx_scrm.sv
// Scoreboard bench for prt_dprx_scrm: keystream-index reference model,
// directed test-plan sequences, then randomized traffic.
module tb_prt_dprx_scrm;

  localparam int unsigned P_LANES = 4;
  localparam int unsigned P_SPL   = 2;
  localparam int unsigned W       = P_LANES * P_SPL * 9;
  localparam int unsigned KS_LEN  = 4096;

  logic         CLK_IN;
  logic         RST_IN;
  logic         CTL_LNK_EN_IN;
  logic         CTL_LANES_IN;
  logic         CTL_SCRM_EN_IN;
  logic [W-1:0] LNK_DAT_IN;
  logic         LNK_VLD_IN;
  logic [W-1:0] LNK_DAT_OUT;
  logic         LNK_VLD_OUT;
  logic [P_LANES-1:0] STA_SYNC_OUT;

  prt_dprx_scrm #(.P_LANES(P_LANES), .P_SPL(P_SPL)) dut (
    .CLK_IN         (CLK_IN),
    .RST_IN         (RST_IN),
    .CTL_LNK_EN_IN  (CTL_LNK_EN_IN),
    .CTL_LANES_IN   (CTL_LANES_IN),
    .CTL_SCRM_EN_IN (CTL_SCRM_EN_IN),
    .LNK_DAT_IN     (LNK_DAT_IN),
    .LNK_VLD_IN     (LNK_VLD_IN),
    .LNK_DAT_OUT    (LNK_DAT_OUT),
    .LNK_VLD_OUT    (LNK_VLD_OUT),
    .STA_SYNC_OUT   (STA_SYNC_OUT)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  typedef struct {
    logic [W-1:0]       dat;
    logic [P_LANES-1:0] sync;
  } exp_t;

  exp_t               q[$];
  logic [7:0]         ks[KS_LEN];
  int                 m_idx[P_LANES];
  logic [P_LANES-1:0] m_sync;
  bit                 m_lanes;
  int                 n_chk  = 0;
  int                 n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Keystream from seed FFFFh as a flat byte table; the model tracks an index into it.
  task automatic build_ks();
    logic [15:0] lf;
    lf = 16'hFFFF;
    for (int i = 0; i < int'(KS_LEN); i++) begin
      for (int b = 0; b < 8; b++) begin
        ks[i][b] = lf[15];
        lf = (lf << 1) ^ (lf[15] ? 16'h0039 : 16'h0000);
      end
    end
  endtask

  task automatic model(input bit rst, input bit en, input bit lanes, input bit scrm,
                       input bit vld, input logic [W-1:0] din);
    exp_t       e;
    logic [8:0] s;
    bit         chg;
    if (rst || !en) begin
      for (int l = 0; l < int'(P_LANES); l++) m_idx[l] = 0;
      m_sync  = '0;
      m_lanes = lanes;
      return;
    end
    chg     = (lanes != m_lanes);
    m_lanes = lanes;
    e.dat   = '0;
    for (int l = 0; l < int'(P_LANES); l++) begin
      if (l >= 2 && !lanes) begin
        m_idx[l]  = 0;
        m_sync[l] = 1'b0;
      end else if (vld) begin
        for (int k = 0; k < int'(P_SPL); k++) begin
          s = din[(l*P_SPL + k)*9 +: 9];
          if (s == 9'h11C) begin
            m_idx[l]  = 0;
            m_sync[l] = 1'b1;
          end else begin
            if (!s[8] && scrm) s[7:0] = s[7:0] ^ ks[m_idx[l] % KS_LEN];
            m_idx[l]++;
          end
          e.dat[(l*P_SPL + k)*9 +: 9] = s;
        end
      end
    end
    if (chg) begin
      for (int l = 0; l < int'(P_LANES); l++) m_idx[l] = 0;
      m_sync = '0;
    end
    e.sync = m_sync;
    if (vld) q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input bit lanes, input bit scrm,
                       input bit vld, input logic [W-1:0] d);
    RST_IN         = rst;
    CTL_LNK_EN_IN  = en;
    CTL_LANES_IN   = lanes;
    CTL_SCRM_EN_IN = scrm;
    LNK_VLD_IN     = vld;
    LNK_DAT_IN     = d;
    model(rst, en, lanes, scrm, vld, d);
    @(posedge CLK_IN);
    #2;
  endtask

  function automatic logic [W-1:0] all_lanes(input logic [8:0] s0, input logic [8:0] s1);
    logic [W-1:0] v;
    for (int l = 0; l < int'(P_LANES); l++) v[l*18 +: 18] = {s1, s0};
    return v;
  endfunction

  // Monitor: pop and compare whenever the DUT presents valid output.
  always @(negedge CLK_IN) begin
    if (LNK_VLD_OUT === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected actual=vld required=no_output");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_dat", LNK_DAT_OUT, e.dat);
        chk("sb_sync", W'(STA_SYNC_OUT), W'(e.sync));
      end
    end
  end

  logic [W-1:0] z0, zsr;

  initial begin
    logic [7:0] ref_ks[6];
    bit cur_lanes, cur_scrm;
    ref_ks = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7};
    build_ks();
    for (int i = 0; i < 6; i++) chk($sformatf("keystream_%0d", i), W'(ks[i]), W'(ref_ks[i]));
    z0  = all_lanes(9'h000, 9'h000);
    zsr = all_lanes(9'h11C, 9'h000);

    // Reset state
    drive(1, 1, 1, 1, 0, z0);
    drive(1, 1, 1, 1, 0, z0);
    chk("rst_dat", LNK_DAT_OUT, '0);
    chk("rst_vld", W'(LNK_VLD_OUT), '0);
    chk("rst_sync", W'(STA_SYNC_OUT), '0);

    // SR + data, scrambler on
    drive(0, 1, 1, 1, 1, zsr);
    chk("sr_lane0", W'(LNK_DAT_OUT[17:0]), W'({9'h0FF, 9'h11C}));
    chk("sr_lane3", W'(LNK_DAT_OUT[71:54]), W'({9'h0FF, 9'h11C}));
    chk("sr_vld", W'(LNK_VLD_OUT), W'(1'b1));
    chk("sr_sync", W'(STA_SYNC_OUT), W'(4'hF));
    drive(0, 1, 1, 1, 1, z0);
    chk("data2_lane0", W'(LNK_DAT_OUT[17:0]), W'({9'h0C0, 9'h017}));

    // Bypass, then enable mid-stream
    drive(0, 1, 1, 0, 1, zsr);
    chk("byp_c1", W'(LNK_DAT_OUT[17:0]), W'({9'h000, 9'h11C}));
    drive(0, 1, 1, 0, 1, z0);
    chk("byp_c2", W'(LNK_DAT_OUT[17:0]), W'({9'h000, 9'h000}));
    drive(0, 1, 1, 1, 1, z0);
    chk("byp_c3", W'(LNK_DAT_OUT[17:0]), W'({9'h0B2, 9'h014}));

    // Non-SR K symbol and sublane-1 reseed
    drive(0, 1, 1, 1, 1, zsr);
    drive(0, 1, 1, 1, 1, all_lanes(9'h1BC, 9'h11C));
    chk("k_pass", W'(LNK_DAT_OUT[17:0]), W'({9'h11C, 9'h1BC}));
    drive(0, 1, 1, 1, 1, z0);
    chk("sub1_reseed", W'(LNK_DAT_OUT[17:0]), W'({9'h017, 9'h0FF}));

    // Lane count: 2 lanes, then back to 4
    drive(0, 1, 0, 1, 0, z0);
    drive(0, 1, 0, 1, 1, zsr);
    chk("lanes2_hi_zero", W'(LNK_DAT_OUT[71:36]), '0);
    chk("lanes2_sync", W'(STA_SYNC_OUT), W'(4'h3));
    drive(0, 1, 1, 1, 0, z0);
    chk("lanes_chg_sync", W'(STA_SYNC_OUT), '0);
    drive(0, 1, 1, 1, 1, zsr);
    chk("lanes4_resync", W'(STA_SYNC_OUT), W'(4'hF));

    // Link disable then valid gaps
    drive(0, 0, 1, 1, 1, zsr);
    chk("dis_dat", LNK_DAT_OUT, '0);
    chk("dis_vld", W'(LNK_VLD_OUT), '0);
    chk("dis_sync", W'(STA_SYNC_OUT), '0);
    drive(0, 1, 1, 1, 1, z0);
    chk("gap_c1", W'(LNK_DAT_OUT[17:0]), W'({9'h017, 9'h0FF}));
    drive(0, 1, 1, 1, 0, z0);
    drive(0, 1, 1, 1, 0, z0);
    chk("gap_vld", W'(LNK_VLD_OUT), '0);
    drive(0, 1, 1, 1, 1, z0);
    chk("gap_c2_lane0", W'(LNK_DAT_OUT[17:0]), W'({9'h014, 9'h0C0}));
    chk("gap_c2_lane3", W'(LNK_DAT_OUT[71:54]), W'({9'h014, 9'h0C0}));

    // Reset mid-stream
    drive(0, 1, 1, 1, 1, z0);
    drive(1, 1, 1, 1, 1, z0);
    chk("mrst_dat", LNK_DAT_OUT, '0);
    chk("mrst_sync", W'(STA_SYNC_OUT), '0);
    drive(0, 1, 1, 1, 1, z0);
    chk("mrst_seed", W'(LNK_DAT_OUT[17:0]), W'({9'h017, 9'h0FF}));

    // Randomized traffic; lane-count changes only on idle cycles
    cur_lanes = 1'b1;
    cur_scrm  = 1'b1;
    for (int i = 0; i < 500; i++) begin
      bit rst, en, ln, vl;
      logic [W-1:0] d;
      logic [8:0]   sym;
      int unsigned  r;
      rst = ($urandom_range(99) == 0);
      en  = ($urandom_range(19) != 0);
      vl  = ($urandom_range(9) < 8);
      ln  = cur_lanes;
      if ($urandom_range(29) == 0) begin
        ln = !cur_lanes;
        vl = 1'b0;
      end
      if ($urandom_range(9) == 0) cur_scrm = !cur_scrm;
      cur_lanes = ln;
      for (int k = 0; k < int'(P_LANES*P_SPL); k++) begin
        r = $urandom_range(9);
        if (r == 0)      sym = 9'h11C;
        else if (r == 1) sym = {1'b1, 8'($urandom)};
        else             sym = {1'b0, 8'($urandom)};
        d[k*9 +: 9] = sym;
      end
      drive(rst, en, ln, cur_scrm, vl, d);
    end

    drive(0, 1, cur_lanes, cur_scrm, 0, z0);
    drive(0, 1, cur_lanes, cur_scrm, 0, z0);
    chk("sb_drained", W'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
